// File: rtl/imem_boot_ctrl_pkg.sv
// rv32i_pkg: shared boot-controller state encoding and instruction-memory constants
package rv32i_pkg;
    typedef enum logic {S_LOAD, S_RUN} state_e;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int IMEM_DEPTH = 1024;
endpackage

// File: rtl/imem_boot_ctrl_if.sv
// imem_boot_ctrl_if: loader and fetch-port signals between host/IF stage and the boot controller
interface imem_boot_ctrl_if #(parameter int AW = 10);
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic [AW:0]   ld_count;
    logic          reload;
    logic          boot_done;
    logic          fetch_req;
    logic [31:0]   fetch_pc;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic          fetch_fault;
    modport slave (
        input  ld_valid, ld_data, ld_last, reload, fetch_req, fetch_pc,
        output ld_ready, ld_count, boot_done, fetch_valid, fetch_instr, fetch_fault
    );
    modport master (
        output ld_valid, ld_data, ld_last, reload, fetch_req, fetch_pc,
        input  ld_ready, ld_count, boot_done, fetch_valid, fetch_instr, fetch_fault
    );
endinterface

// File: rtl/imem_boot_ctrl_ram.sv
// imem_ram: single-port DEPTHx32 instruction RAM, synchronous write and registered read
module imem_ram #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // one shared port: write while loading, registered read while running
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: loads a program into instruction memory, then serves one-cycle fetches with fault detection
module imem_boot_ctrl
    import rv32i_pkg::*;
#(
    parameter  int DEPTH = IMEM_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input logic clk,
    input logic rst,
    imem_boot_ctrl_if.slave bus
);
    state_e      state_q;
    logic [AW:0] cnt_q;
    logic        valid_q, fault_q;
    logic [31:0] rdata;
    logic        accept, fetch_acc, fault, last_word;

    // reload always wins over a same-cycle loader word or fetch request
    always_comb begin
        accept    = bus.ld_valid && bus.ld_ready && !bus.reload;
        fetch_acc = state_q == S_RUN && bus.fetch_req && !bus.reload && !rst;
        fault     = bus.fetch_pc[1:0] != 2'b00 || bus.fetch_pc[31:2] >= 30'(cnt_q);
        last_word = bus.ld_last || cnt_q == (AW+1)'(DEPTH - 1);
    end

    imem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (accept),
        .re_i    (fetch_acc),
        .addr_i  (state_q == S_LOAD ? cnt_q[AW-1:0] : bus.fetch_pc[AW+1:2]),
        .wdata_i (bus.ld_data),
        .rdata_o (rdata)
    );

    // phase FSM, load counter and the one-cycle fetch response pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= fetch_acc;
            fault_q <= fetch_acc && fault;
            if (bus.reload) begin
                state_q <= S_LOAD;
                cnt_q   <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                if (last_word) state_q <= S_RUN;
            end
        end
    end

    assign bus.ld_ready    = state_q == S_LOAD && !rst;
    assign bus.ld_count    = cnt_q;
    assign bus.boot_done   = state_q == S_RUN;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_instr = !valid_q ? '0 : fault_q ? NOP_INSTR : rdata;
endmodule
